// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller: merges stage stall requests, sequences exception flushes
// (deferred while MEM waits on data SRAM), and tracks stall cycles plus a stuck-pipeline watchdog.
module pipe_stall_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter int          TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        perf_clr,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cycles,
    output logic        stall_timeout
);

    localparam logic [0:0]  IDLE       = 1'b0;
    localparam logic [0:0]  PEND       = 1'b1;
    localparam logic [31:0] EXC_ERET   = 32'h0000000E;
    localparam logic [5:0]  STALL_MEM  = 6'b011111;
    localparam logic [5:0]  STALL_EX   = 6'b001111;
    localparam logic [5:0]  STALL_ID   = 6'b000111;
    localparam logic [5:0]  STALL_IF   = 6'b000011;
    localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

    logic [0:0]  state_q, state_d;
    logic [31:0] exctype_q, exctype_d;
    logic [31:0] target_q, target_d;
    logic [31:0] cyc_q, cyc_d;
    logic [15:0] consec_q, consec_d;
    logic        to_q, to_d;

    logic        exc;
    logic [31:0] exc_target;
    logic [5:0]  req_stall;
    logic [5:0]  stall_c;
    logic        flush_c;
    logic [31:0] new_pc_c;
    logic        stalled;

    assign exc        = |excepttype_i;
    assign exc_target = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;

    always_comb begin
        if (stallreq_mem)     req_stall = STALL_MEM;
        else if (stallreq_ex) req_stall = STALL_EX;
        else if (stallreq_id) req_stall = STALL_ID;
        else if (stallreq_if) req_stall = STALL_IF;
        else                  req_stall = 6'b000000;
    end

    always_comb begin
        state_d   = state_q;
        exctype_d = exctype_q;
        target_d  = target_q;
        stall_c   = req_stall;
        flush_c   = 1'b0;
        new_pc_c  = 32'h0;
        case (state_q)
            IDLE: begin
                if (exc) begin
                    if (stallreq_mem) begin
                        // MEM is mid-access: hold everything and flush once the SRAM answers
                        stall_c   = STALL_MEM;
                        exctype_d = excepttype_i;
                        target_d  = exc_target;
                        state_d   = PEND;
                    end else begin
                        stall_c  = 6'b000000;
                        flush_c  = 1'b1;
                        new_pc_c = exc_target;
                    end
                end
            end
            PEND: begin
                if (stallreq_mem) begin
                    stall_c = STALL_MEM;
                end else begin
                    stall_c  = 6'b000000;
                    flush_c  = 1'b1;
                    new_pc_c = target_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced quiet for the whole time reset is held, not just from the next edge.
    assign stall         = rst ? 6'b000000 : stall_c;
    assign flush         = rst ? 1'b0 : flush_c;
    assign new_pc        = rst ? 32'h0 : new_pc_c;
    assign stall_cycles  = cyc_q;
    assign stall_timeout = to_q;

    assign stalled = stall[0] && !flush;

    always_comb begin
        cyc_d = cyc_q;
        if (perf_clr)                             cyc_d = 32'h0;
        else if (stall[0] && cyc_q != 32'hFFFFFFFF) cyc_d = cyc_q + 32'd1;

        consec_d = 16'h0;
        if (stalled) consec_d = (consec_q == 16'hFFFF) ? consec_q : consec_q + 16'd1;

        to_d = to_q | (stalled && consec_q >= TIMEOUT_M1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            exctype_q <= 32'h0;
            target_q  <= 32'h0;
            cyc_q     <= 32'h0;
            consec_q  <= 16'h0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            exctype_q <= exctype_d;
            target_q  <= target_d;
            cyc_q     <= cyc_d;
            consec_q  <= consec_d;
            to_q      <= to_d;
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallreq_if = 1'b0, stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
    logic [31:0] excepttype_i = 32'h0, cp0_epc_i = 32'h0;
    logic        perf_clr = 1'b0;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc, stall_cycles;
    logic        stall_timeout;

    typedef struct {
        string       name;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic [31:0] cyc;
        logic        to;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_cyc = 32'h0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.EXC_VECTOR(32'hBFC00380), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .excepttype_i(excepttype_i), .cp0_epc_i(cp0_epc_i), .perf_clr(perf_clr),
        .stall(stall), .flush(flush), .new_pc(new_pc),
        .stall_cycles(stall_cycles), .stall_timeout(stall_timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge and queue what the outputs must be this cycle.
    task automatic step(input string name, input logic r, input logic [3:0] req, input logic [31:0] et,
                        input logic [31:0] epc, input logic pclr,
                        input logic [5:0] es, input logic ef, input logic [31:0] epc_exp, input logic eto);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r;
        stallreq_mem = req[3];
        stallreq_ex  = req[2];
        stallreq_id  = req[1];
        stallreq_if  = req[0];
        excepttype_i = et;
        cp0_epc_i    = epc;
        perf_clr     = pclr;
        if (r) exp_cyc = 32'h0;
        e.name = name; e.stall = es; e.flush = ef; e.pc = epc_exp; e.cyc = exp_cyc; e.to = eto;
        sb_q.push_back(e);
        if (r || pclr)  exp_cyc = 32'h0;
        else if (es[0]) exp_cyc = exp_cyc + 32'd1;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk({e.name, ".stall"},   {26'h0, stall}, {26'h0, e.stall});
            chk({e.name, ".flush"},   {31'h0, flush}, {31'h0, e.flush});
            chk({e.name, ".new_pc"},  new_pc, e.pc);
            chk({e.name, ".cycles"},  stall_cycles, e.cyc);
            chk({e.name, ".timeout"}, {31'h0, stall_timeout}, {31'h0, e.to});
        end
    end

    initial begin
        // req bits: {mem, ex, id, if}
        step("rst0", 1, 4'b0000, 32'h0, 32'h0, 0, 6'b000000, 0, 32'h0, 0);
        step("rst1", 1, 4'b1111, 32'hC, 32'h0, 0, 6'b000000, 0, 32'h0, 0);
        step("idle", 0, 4'b0000, 32'h0, 32'h0, 0, 6'b000000, 0, 32'h0, 0);

        step("pri_if_ex",  0, 4'b0101, 32'h0, 32'h0, 0, 6'b001111, 0, 32'h0, 0);
        step("pri_mem",    0, 4'b1101, 32'h0, 32'h0, 0, 6'b011111, 0, 32'h0, 0);
        step("pri_id",     0, 4'b0011, 32'h0, 32'h0, 0, 6'b000111, 0, 32'h0, 0);
        step("pri_if",     0, 4'b0001, 32'h0, 32'h0, 0, 6'b000011, 0, 32'h0, 0);
        step("pri_none",   0, 4'b0000, 32'h0, 32'h0, 0, 6'b000000, 0, 32'h0, 0);

        step("exc_imm",    0, 4'b0100, 32'hC, 32'h0, 0, 6'b000000, 1, 32'hBFC00380, 0);
        step("exc_after",  0, 4'b0000, 32'h0, 32'h0, 0, 6'b000000, 0, 32'h0, 0);

        step("eret",       0, 4'b0000, 32'hE, 32'h80001234, 0, 6'b000000, 1, 32'h80001234, 0);
        step("eret_after", 0, 4'b0000, 32'h0, 32'h80001234, 0, 6'b000000, 0, 32'h0, 0);

        step("def_0",      0, 4'b1000, 32'h4, 32'h11111111, 0, 6'b011111, 0, 32'h0, 0);
        step("def_1",      0, 4'b1000, 32'hE, 32'h22222222, 0, 6'b011111, 0, 32'h0, 0);
        step("def_2",      0, 4'b1000, 32'h0, 32'h33333333, 0, 6'b011111, 0, 32'h0, 0);
        step("def_flush",  0, 4'b0000, 32'h0, 32'h0, 0, 6'b000000, 1, 32'hBFC00380, 0);
        step("def_idle",   0, 4'b0000, 32'h0, 32'h0, 0, 6'b000000, 0, 32'h0, 0);

        step("deret_0",    0, 4'b1000, 32'hE, 32'h80005678, 0, 6'b011111, 0, 32'h0, 0);
        step("deret_1",    0, 4'b1010, 32'h0, 32'h0, 0, 6'b011111, 0, 32'h0, 0);
        step("deret_fl",   0, 4'b0000, 32'hC, 32'h0, 0, 6'b000000, 1, 32'h80005678, 0);
        step("deret_idle", 0, 4'b0000, 32'h0, 32'h0, 0, 6'b000000, 0, 32'h0, 0);

        step("rstp_pend",  0, 4'b1000, 32'h4, 32'h0, 0, 6'b011111, 0, 32'h0, 0);
        step("rstp_rst",   1, 4'b1000, 32'h4, 32'h0, 0, 6'b000000, 0, 32'h0, 0);
        step("rstp_rel",   0, 4'b0000, 32'h0, 32'h0, 0, 6'b000000, 0, 32'h0, 0);
        step("rstp_rel2",  0, 4'b0000, 32'h0, 32'h0, 0, 6'b000000, 0, 32'h0, 0);

        for (int i = 0; i < 8; i++)
            step("wd_stall", 0, 4'b0010, 32'h0, 32'h0, 0, 6'b000111, 0, 32'h0, 0);
        step("wd_set",     0, 4'b0000, 32'h0, 32'h0, 0, 6'b000000, 0, 32'h0, 1);
        step("wd_clr",     0, 4'b0000, 32'h0, 32'h0, 1, 6'b000000, 0, 32'h0, 1);
        step("wd_sticky",  0, 4'b0000, 32'h0, 32'h0, 0, 6'b000000, 0, 32'h0, 1);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
